seq_scan_ctrl: RTL and testbench

Job controller that feeds a bit-serial "1101" sequence detector from a word-wide stream. A requester programs a word count and pulses `start`. The block then accepts words over a valid/ready handshake, serialises each word MSB-first into an embedded overlapping Mealy 1101 detector, and counts matches. It pulses `done` when the job ends. It sits between a word-oriented producer and the serial pattern-detection path, and owns sequencing, flow control and match accounting.

---
 rtl/seq_scan_ctrl.sv | 77 +++++++
 tb/tb_seq_scan_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: job controller serialising words MSB-first into an overlapping 1101 detector; ports: start/num_words job request, in_valid/in_data/in_ready word handshake, hit/hit_count match reporting, busy/done job status
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       num_words,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;
  state_t state, state_nx;
  det_t det, det_nx;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0] bit_idx;
  logic [7:0] words_left;
  logic b, match, last_bit;
  always_comb begin
    b = sreg[WIDTH-1];
    det_nx = b ? ((det == S0) ? S1 : (det == S3) ? S1 : S2)
               : ((det == S2) ? S3 : S0);
    match = (det == S3) && b;
    last_bit = bit_idx == '0;
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ((num_words != 8'd0) ? LOAD : DONE) : IDLE;
      LOAD:    state_nx = in_valid ? SHIFT : LOAD;
      SHIFT:   state_nx = last_bit ? ((words_left == 8'd1) ? DONE : LOAD) : SHIFT;
      default: state_nx = IDLE;
    endcase
  end
  assign in_ready = state == LOAD;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      det <= S0;
      sreg <= '0;
      bit_idx <= '0;
      words_left <= '0;
      hit <= 1'b0;
      hit_count <= '0;
    end else begin
      state <= state_nx;
      hit <= (state == SHIFT) && match;
      case (state)
        IDLE: if (start) begin
          hit_count <= '0;
          det <= S0;
          words_left <= num_words;
        end
        LOAD: if (in_valid) begin
          sreg <= in_data;
          bit_idx <= BW'(WIDTH - 1);
        end
        SHIFT: begin
          det <= det_nx;
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          bit_idx <= bit_idx - 1'b1;
          if (match && !(&hit_count)) hit_count <= hit_count + 1'b1;
          if (last_bit) words_left <= words_left - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed self-checking bench for seq_scan_ctrl, with a CNT_W=2 twin for saturation
module tb_seq_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] num_words = '0, in_data = '0;
  logic in_ready, hit, busy, done, in_ready2, hit2, busy2, done2;
  logic [7:0] hit_count;
  logic [1:0] hit_count2;
  logic [7:0] wq [4];
  int errors = 0, checks = 0;
  int done_k, hits, hits2, first_hit, rdy_seen;
  always #5 clk = ~clk;
  seq_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .hit(hit), .hit_count(hit_count),
    .busy(busy), .done(done)
  );
  seq_scan_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready2), .hit(hit2), .hit_count(hit_count2),
    .busy(busy2), .done(done2)
  );
  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  // k counts cycles after the start edge; cycle k is observed at its negedge
  task automatic job(input int n, input int stall, input bit poke);
    int idx = 0, st = stall;
    done_k = -1; hits = 0; hits2 = 0; first_hit = -1; rdy_seen = 0;
    @(negedge clk);
    start = 1'b1;
    num_words = n[7:0];
    @(posedge clk);
    for (int k = 1; k <= 200 && done_k < 0; k++) begin
      @(negedge clk);
      start = poke && k == 3;
      if (poke && k == 3) num_words = 8'd0;
      if (hit) begin
        hits++;
        if (first_hit < 0) first_hit = k;
      end
      if (hit2) hits2++;
      if (in_ready) rdy_seen++;
      if (done) done_k = k;
      in_valid = 1'b0;
      if (in_ready && idx < n) begin
        if (st > 0) st--;
        else begin
          in_valid = 1'b1;
          in_data = wq[idx];
          idx++;
        end
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_hit", hit, 0);
    check("rst_count", hit_count, 0);
    rst = 1'b0;
    wq[0] = 8'hD0;
    job(1, 0, 0);
    check("d0_done", done_k, 10);
    check("d0_first_hit", first_hit, 6);
    check("d0_hits", hits, 1);
    check("d0_count", hit_count, 1);
    check("d0_ready", rdy_seen, 1);
    wq[0] = 8'hDB;
    job(1, 0, 0);
    check("db_hits", hits, 2);
    check("db_count", hit_count, 2);
    check("db_done", done_k, 10);
    wq[0] = 8'h6D;
    job(1, 0, 0);
    check("6d_hits", hits, 2);
    check("6d_count", hit_count, 2);
    wq[0] = 8'h01; wq[1] = 8'hA0;
    job(2, 0, 0);
    check("cross_hits", hits, 1);
    check("cross_first_hit", first_hit, 14);
    check("cross_count", hit_count, 1);
    check("cross_done", done_k, 19);
    wq[0] = 8'hD0;
    job(1, 5, 1);
    check("stall_done", done_k, 15);
    check("stall_ready", rdy_seen, 6);
    check("stall_hits", hits, 1);
    check("stall_count", hit_count, 1);
    job(0, 0, 0);
    check("zero_done", done_k, 1);
    check("zero_ready", rdy_seen, 0);
    check("zero_count", hit_count, 0);
    for (int i = 0; i < 4; i++) wq[i] = 8'hDB;
    job(4, 0, 0);
    check("sat_hits", hits, 8);
    check("sat_hits2", hits2, 8);
    check("sat_count8", hit_count, 8);
    check("sat_count2", hit_count2, 3);
    check("sat_done", done_k, 37);
    @(negedge clk);
    start = 1'b1; num_words = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'hDB;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_count", hit_count, 1);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_hit", hit, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count", hit_count, 0);
    @(negedge clk);
    rst = 1'b0;
    wq[0] = 8'hD0;
    job(1, 0, 0);
    check("post_rst_count", hit_count, 1);
    check("post_rst_done", done_k, 10);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
